// File: rtl/noc_ser_pkg.sv
// Shared sizing helpers and the flit record for the NoC serializer shims.
package noc_ser_pkg;

  function automatic int flit_width(input int tdata_w, input int sf);
    return tdata_w / sf;
  endfunction

  function automatic int dest_width(input int tid_w, input int tdest_w);
    return tid_w + tdest_w;
  endfunction

  function automatic int credit_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int sf);
    return (sf > 1) ? $clog2(sf) : 1;
  endfunction

  localparam int DEF_FLIT_W = 128;
  localparam int DEF_DEST_W = 6;

  typedef struct packed {
    logic [DEF_FLIT_W-1:0] data;
    logic [DEF_DEST_W-1:0] dest;
    logic                  is_tail;
  } noc_flit_t;

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter starting full at DEPTH; saturates and raises a sticky flag on a surplus return.
module noc_credit_counter
  import noc_ser_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = credit_cnt_width(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o,
  output logic ovf_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (inc_i && !dec_i) begin
      if (count_q == FULL) ovf_d = 1'b1;
      else                 count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= FULL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign avail_o = (count_q != '0);
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/axis_credit_serializer.sv
// AXIS beat -> SERIALIZATION_FACTOR flits with credit flow control and per-packet dest lock.
// Optional tlast-beat trimming by tkeep when AXIS_SER_TRIM_EN is defined.
module axis_credit_serializer
  import noc_ser_pkg::*;
#(
  parameter int TDATA_WIDTH          = 512,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 axis_in_tvalid,
  output logic                                                 axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]                               axis_in_tdata,
  input  logic                                                 axis_in_tlast,
  input  logic [TID_WIDTH-1:0]                                 axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]                               axis_in_tdest,
`ifdef AXIS_SER_TRIM_EN
  input  logic [TDATA_WIDTH/8-1:0]                             axis_in_tkeep,
`endif
  output logic [flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR)-1:0] data_out,
  output logic [dest_width(TID_WIDTH, TDEST_WIDTH)-1:0]        dest_out,
  output logic                                                 is_tail_out,
  output logic                                                 send_out,
  input  logic                                                 credit_in,
  output logic                                                 err_credit_ovf
);

  localparam int FLIT_WIDTH = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR);
  localparam int DEST_WIDTH = dest_width(TID_WIDTH, TDEST_WIDTH);
  localparam int IDX_W      = idx_width(SERIALIZATION_FACTOR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  hold_last_q, hold_last_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pkt_open_q, pkt_open_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  ready_en_q;
  flit_t                 out_q, out_d;
  logic                  send_q;

  logic             credit_avail, credit_ovf;
  logic             send, last_flit, beat_done, tail_send, accept;
  logic [IDX_W-1:0] last_idx;

`ifdef AXIS_SER_TRIM_EN
  localparam int KEEP_PER_FLIT = FLIT_WIDTH / 8;
  logic [TDATA_WIDTH/8-1:0] hold_keep_q, hold_keep_d;
  logic [IDX_W-1:0]         trim_idx;

  // Highest flit holding any kept byte; flit 0 when nothing is kept.
  always_comb begin
    trim_idx = '0;
    for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
      if (|hold_keep_q[k*KEEP_PER_FLIT +: KEEP_PER_FLIT]) trim_idx = IDX_W'(k);
    end
  end

  assign last_idx = hold_last_q ? trim_idx : LAST_IDX;
`else
  assign last_idx = LAST_IDX;
`endif

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_credits (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (credit_in),
    .dec_i   (send),
    .avail_o (credit_avail),
    .ovf_o   (credit_ovf)
  );

  assign send           = hold_valid_q & credit_avail;
  assign last_flit      = (idx_q == last_idx);
  assign beat_done      = send & last_flit;
  assign tail_send      = beat_done & hold_last_q;
  assign axis_in_tready = ready_en_q & (~hold_valid_q | beat_done);
  assign accept         = axis_in_tvalid & axis_in_tready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    idx_d        = idx_q;
    pkt_open_d   = pkt_open_q;
    dest_d       = dest_q;
`ifdef AXIS_SER_TRIM_EN
    hold_keep_d  = hold_keep_q;
`endif
    if (send)      idx_d        = last_flit ? '0 : idx_q + IDX_W'(1);
    if (beat_done) hold_valid_d = 1'b0;
    if (tail_send) pkt_open_d   = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = axis_in_tdata;
      hold_last_d  = axis_in_tlast;
`ifdef AXIS_SER_TRIM_EN
      hold_keep_d  = axis_in_tkeep;
`endif
      // A beat arriving as the previous tail leaves starts a new packet.
      if (!pkt_open_q || tail_send) begin
        dest_d     = {axis_in_tid, axis_in_tdest};
        pkt_open_d = 1'b1;
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (send) begin
      out_d.data    = hold_data_q[idx_q];
      out_d.dest    = dest_q;
      out_d.is_tail = tail_send;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      idx_q        <= '0;
      pkt_open_q   <= 1'b0;
      ready_en_q   <= 1'b0;
      send_q       <= 1'b0;
      out_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      idx_q        <= idx_d;
      pkt_open_q   <= pkt_open_d;
      ready_en_q   <= 1'b1;
      send_q       <= send;
      out_q        <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    dest_q      <= dest_d;
`ifdef AXIS_SER_TRIM_EN
    hold_keep_q <= hold_keep_d;
`endif
  end

  assign data_out       = out_q.data;
  assign dest_out       = out_q.dest;
  assign is_tail_out    = out_q.is_tail;
  assign send_out       = send_q;
  assign err_credit_ovf = credit_ovf;

endmodule

// File: tb/tb_axis_credit_serializer.sv
// Directed bench for axis_credit_serializer (default parameters: 512b beats, 4 x 128b flits, 4 credits).
module tb_axis_credit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         tvalid, tready, tlast;
  logic [511:0] tdata;
  logic [1:0]   tid;
  logic [3:0]   tdest;
  logic [63:0]  tkeep;
  logic [127:0] data_out;
  logic [5:0]   dest_out;
  logic         is_tail_out, send_out, credit_in, err_ovf;

  axis_credit_serializer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axis_in_tvalid (tvalid),
    .axis_in_tready (tready),
    .axis_in_tdata  (tdata),
    .axis_in_tlast  (tlast),
    .axis_in_tid    (tid),
    .axis_in_tdest  (tdest),
`ifdef AXIS_SER_TRIM_EN
    .axis_in_tkeep  (tkeep),
`endif
    .data_out       (data_out),
    .dest_out       (dest_out),
    .is_tail_out    (is_tail_out),
    .send_out       (send_out),
    .credit_in      (credit_in),
    .err_credit_ovf (err_ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       vld;
    logic [7:0] base;
    logic       last;
    logic [1:0] id;
    logic [3:0] dst;
    logic       cr;
    logic       e_rdy;
    logic       e_send;
    logic [7:0] e_b;
    logic [5:0] e_dest;
    logic       e_tail;
  } vec_t;

  typedef struct {
    logic [7:0]  base;
    logic        last;
    logic [1:0]  id;
    logic [3:0]  dst;
    logic [63:0] keep;
  } beat_t;

  typedef struct {
    logic [7:0] b;
    logic [5:0] dest;
    logic       tail;
  } fexp_t;

  typedef struct {
    logic [127:0] data;
    logic [5:0]   dest;
    logic         tail;
  } fobs_t;

  vec_t  tbl[$];
  beat_t beats[$];
  fexp_t expq[$];
  fobs_t obs[$];
  int    sent = 0;
  int    returned = 0;

  function automatic logic [511:0] mk(input logic [7:0] b);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 16; j++)
        d[k*128 + j*8 +: 8] = b + 8'(k);
    return d;
  endfunction

  function automatic logic [127:0] fl(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic row(input logic vld, input logic [7:0] base, input logic last, input logic [1:0] id,
                     input logic [3:0] dst, input logic cr, input logic e_rdy, input logic e_send,
                     input logic [7:0] e_b, input logic [5:0] e_dest, input logic e_tail);
    vec_t v;
    v = '{vld, base, last, id, dst, cr, e_rdy, e_send, e_b, e_dest, e_tail};
    tbl.push_back(v);
  endtask

  // Queue a packet and its expected flits; lastn = flits emitted by the last beat.
  task automatic add_packet(input int nb, input logic [7:0] base, input logic [1:0] id,
                            input logic [3:0] d0, input logic [3:0] d1,
                            input logic [63:0] lastkeep, input int lastn);
    for (int i = 0; i < nb; i++) begin
      beat_t bt;
      int    nf;
      bt.base = base + 8'(4 * i);
      bt.last = (i == nb - 1);
      bt.id   = id;
      bt.dst  = (i == 0) ? d0 : d1;
      bt.keep = bt.last ? lastkeep : '1;
      beats.push_back(bt);
      nf = bt.last ? lastn : 4;
      for (int k = 0; k < nf; k++) begin
        fexp_t f;
        f.b    = bt.base + 8'(k);
        f.dest = {id, d0};
        f.tail = bt.last && (k == nf - 1);
        expq.push_back(f);
      end
    end
  endtask

  // One clock: mode 0 = no credit returns, mode 1 = return one per flit already seen.
  task automatic cycle(input int mode);
    logic hs;
    tvalid = (beats.size() > 0);
    if (beats.size() > 0) begin
      tdata = mk(beats[0].base);
      tlast = beats[0].last;
      tid   = beats[0].id;
      tdest = beats[0].dst;
      tkeep = beats[0].keep;
    end
    credit_in = (mode == 1) && (returned < sent);
    @(negedge clk);
    if (send_out) begin
      fobs_t o;
      o.data = data_out;
      o.dest = dest_out;
      o.tail = is_tail_out;
      obs.push_back(o);
      sent++;
    end
    hs = tvalid && tready;
    if (credit_in) returned++;
    @(posedge clk);
    #1;
    if (hs) void'(beats.pop_front());
    tvalid    = 1'b0;
    credit_in = 1'b0;
  endtask

  task automatic run_until(input int mode, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (obs.size() < target && n < budget) begin
      cycle(mode);
      n++;
    end
    vectors++;
    if (obs.size() < target) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d flits expected %0d", name, obs.size(), target);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (returned < sent || beats.size() > 0); n++) cycle(1);
  endtask

  task automatic check_flits(input string name);
    int n;
    vectors++;
    if (obs.size() != expq.size()) begin
      miscompares++;
      $display("FAIL %s count: got %0d flits expected %0d", name, obs.size(), expq.size());
    end
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs[i].data !== fl(expq[i].b) || obs[i].dest !== expq[i].dest || obs[i].tail !== expq[i].tail) begin
        miscompares++;
        $display("FAIL %s flit%0d: got data=%h dest=%h tail=%b expected byte=%h dest=%h tail=%b",
                 name, i, obs[i].data[31:0], obs[i].dest, obs[i].tail, expq[i].b, expq[i].dest, expq[i].tail);
      end
    end
    obs.delete();
    expq.delete();
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tid = '0; tdest = '0;
    tkeep = '1; credit_in = 1'b0;

    // Single-beat packet, then back-to-back three-beat packet with credits looped back.
    row(1, 8'h00, 1, 2'd1, 4'd5, 0,  1, 0, 8'h00, 6'h00, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 0,  0, 0, 8'h00, 6'h00, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 0,  0, 1, 8'h00, 6'h15, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 0,  0, 1, 8'h01, 6'h15, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 0,  1, 1, 8'h02, 6'h15, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 0,  1, 1, 8'h03, 6'h15, 1);
    for (int i = 0; i < 4; i++) row(0, 8'h00, 0, 2'd0, 4'd0, 1,  1, 0, 8'h00, 6'h00, 0);
    row(1, 8'h40, 0, 2'd2, 4'd3, 0,  1, 0, 8'h00, 6'h00, 0);
    row(1, 8'h50, 0, 2'd2, 4'd3, 0,  0, 0, 8'h00, 6'h00, 0);
    row(1, 8'h50, 0, 2'd2, 4'd3, 1,  0, 1, 8'h40, 6'h23, 0);
    row(1, 8'h50, 0, 2'd2, 4'd3, 1,  0, 1, 8'h41, 6'h23, 0);
    row(1, 8'h50, 0, 2'd2, 4'd3, 1,  1, 1, 8'h42, 6'h23, 0);
    row(1, 8'h60, 1, 2'd2, 4'd3, 1,  0, 1, 8'h43, 6'h23, 0);
    row(1, 8'h60, 1, 2'd2, 4'd3, 1,  0, 1, 8'h50, 6'h23, 0);
    row(1, 8'h60, 1, 2'd2, 4'd3, 1,  0, 1, 8'h51, 6'h23, 0);
    row(1, 8'h60, 1, 2'd2, 4'd3, 1,  1, 1, 8'h52, 6'h23, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 1,  0, 1, 8'h53, 6'h23, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 1,  0, 1, 8'h60, 6'h23, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 1,  0, 1, 8'h61, 6'h23, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 1,  1, 1, 8'h62, 6'h23, 0);
    row(0, 8'h00, 0, 2'd0, 4'd0, 1,  1, 1, 8'h63, 6'h23, 1);
    row(0, 8'h00, 0, 2'd0, 4'd0, 0,  1, 0, 8'h00, 6'h00, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 128'(tready), 128'd0);
    chk("rst_send",   128'(send_out), 128'd0);
    chk("rst_data",   data_out, 128'd0);
    chk("rst_dest",   128'(dest_out), 128'd0);
    chk("rst_tail",   128'(is_tail_out), 128'd0);
    chk("rst_ovf",    128'(err_ovf), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      logic ok;
      tvalid = tbl[i].vld; tdata = mk(tbl[i].base); tlast = tbl[i].last;
      tid = tbl[i].id; tdest = tbl[i].dst; credit_in = tbl[i].cr; tkeep = '1;
      @(negedge clk);
      ok = (tready === tbl[i].e_rdy) && (send_out === tbl[i].e_send);
      if (tbl[i].e_send)
        ok = ok && (data_out === fl(tbl[i].e_b)) && (dest_out === tbl[i].e_dest)
                && (is_tail_out === tbl[i].e_tail);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL vec%0d: got rdy=%b send=%b data=%h dest=%h tail=%b expected rdy=%b send=%b byte=%h dest=%h tail=%b",
                 i, tready, send_out, data_out[31:0], dest_out, is_tail_out,
                 tbl[i].e_rdy, tbl[i].e_send, tbl[i].e_b, tbl[i].e_dest, tbl[i].e_tail);
      end
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0; credit_in = 1'b0;

    // Three-beat packet, tdest changes mid-packet, credits withheld then returned.
    add_packet(3, 8'h10, 2'd1, 4'd5, 4'd9, '1, 4);
    repeat (12) cycle(0);
    chk("stall_flits", 128'(obs.size()), 128'd4);
    chk("stall_tready", 128'(tready), 128'd0);
    run_until(1, 12, 80, "resume");
    drain();
    check_flits("lock");

    // Long packet: send and credit together, then starve and count outstanding flits.
    add_packet(8, 8'h90, 2'd0, 4'd7, 4'd7, '1, 4);
    repeat (20) cycle(1);
    repeat (10) cycle(0);
    chk("outstanding", 128'(sent - returned), 128'd4);
    chk("starved_send", 128'(send_out), 128'd0);
    run_until(1, 32, 200, "long");
    drain();
    check_flits("long");
    chk("ovf_before", 128'(err_ovf), 128'd0);
    credit_in = 1'b1;
    @(posedge clk);
    #1;
    credit_in = 1'b0;
    chk("ovf_set", 128'(err_ovf), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_sticky", 128'(err_ovf), 128'd1);

    // Reset in the middle of a beat, then a fresh packet on the restored credits.
    add_packet(1, 8'hC0, 2'd2, 4'd1, 4'd1, '1, 4);
    run_until(0, 2, 20, "pre_reset");
    rst_n = 1'b0;
    #1;
    chk("mid_send",   128'(send_out), 128'd0);
    chk("mid_data",   data_out, 128'd0);
    chk("mid_dest",   128'(dest_out), 128'd0);
    chk("mid_tail",   128'(is_tail_out), 128'd0);
    chk("mid_tready", 128'(tready), 128'd0);
    chk("mid_ovf",    128'(err_ovf), 128'd0);
    beats.delete(); obs.delete(); expq.delete();
    sent = 0; returned = 0; tvalid = 1'b0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_packet(1, 8'hD0, 2'd3, 4'd10, 4'd10, '1, 4);
    run_until(0, 4, 20, "post_reset");
    repeat (3) cycle(0);
    check_flits("post_reset");
    drain();

`ifdef AXIS_SER_TRIM_EN
    add_packet(1, 8'hE0, 2'd1, 4'd2, 4'd2, 64'h0000_0000_0000_00FF, 1);
    run_until(1, 1, 20, "trim_ff");
    repeat (6) cycle(1);
    check_flits("trim_ff");
    add_packet(1, 8'hF0, 2'd1, 4'd3, 4'd3, 64'h0, 1);
    run_until(1, 1, 20, "trim_zero");
    repeat (6) cycle(1);
    check_flits("trim_zero");
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
